conv3x3_stream: RTL

CONV3X3_STREAM -- requirements
Module: conv3x3_stream

---
 rtl/conv3x3_stream.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 Sobel edge filter.
// The block accepts a byte stream made of a 4-byte dimension header followed by pixels.
// It emits a 4-byte header giving the interior dimensions, followed by one gradient
// magnitude per interior pixel.
module conv3x3_stream #(
    parameter int DATA_W = 8,
    parameter int MAX_W  = 640,
    parameter int DIM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    input  logic              ready_out,
    output logic              err
);

    localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int GW = DATA_W + 3;   // signed gradient width
    localparam int SW = DATA_W + 4;   // |Gx|+|Gy| before saturation

    typedef enum logic [1:0] {HDR_IN, HDR_OUT, PIX, ERR} state_t;

    state_t             state_q;
    logic [1:0]         hcnt_q;
    logic [1:0]         ocnt_q;
    logic [DIM_W-1:0]   w_q, h_q, col_q, row_q;
    logic [1:0]         mode_q;
    logic               last_q;
    logic [DATA_W-1:0]  data_q;
    logic               valid_q;
    logic               err_q;

    // Two previous image rows, indexed by column.
    logic [DATA_W-1:0]  lb0_q [MAX_W];   // row r-1
    logic [DATA_W-1:0]  lb1_q [MAX_W];   // row r-2
    // Left two columns of the window; the right column is formed from the
    // line-buffer outputs and the incoming pixel in the cycle it is accepted.
    logic [DATA_W-1:0]  win_q [3][2];

    logic               in_xfer, out_xfer, pix_acc;
    logic [AW-1:0]      col_idx;
    logic [DATA_W-1:0]  top_d, mid_d;
    logic [DATA_W-1:0]  p00, p01, p02, p10, p11, p12, p20, p21, p22;
    logic signed [GW-1:0] gx_d, gy_d;
    logic [GW-1:0]      ax_d, ay_d;
    logic [SW-1:0]      sum_d;
    logic [DATA_W-1:0]  res_d;
    logic [DIM_W-1:0]   h_full_d, wdim_d, hdim_d;
    logic               bad_d;

    function automatic logic signed [GW-1:0] ext(input logic [DATA_W-1:0] v);
        return signed'({3'b000, v});
    endfunction

    function automatic logic [GW-1:0] absv(input logic signed [GW-1:0] v);
        return v[GW-1] ? GW'(-v) : GW'(v);
    endfunction

    function automatic logic [DATA_W-1:0] sat(input logic [SW-1:0] v);
        return (|v[SW-1:DATA_W]) ? {DATA_W{1'b1}} : v[DATA_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] hdr_byte(input logic [1:0] idx,
                                                   input logic [DIM_W-1:0] wd,
                                                   input logic [DIM_W-1:0] hd);
        logic [DATA_W-1:0] b;
        case (idx)
            2'd0:    b = wd[DATA_W-1:0];
            2'd1:    b = DATA_W'(wd >> DATA_W);
            2'd2:    b = hd[DATA_W-1:0];
            default: b = DATA_W'(hd >> DATA_W);
        endcase
        return b;
    endfunction

    assign in_xfer  = valid_in && ready_in;
    assign out_xfer = valid_q && ready_out;
    assign pix_acc  = in_xfer && (state_q == PIX);

    assign col_idx = col_q[AW-1:0];
    assign top_d   = lb1_q[col_idx];
    assign mid_d   = lb0_q[col_idx];

    assign p00 = win_q[0][0];  assign p01 = win_q[0][1];  assign p02 = top_d;
    assign p10 = win_q[1][0];  assign p11 = win_q[1][1];  assign p12 = mid_d;
    assign p20 = win_q[2][0];  assign p21 = win_q[2][1];  assign p22 = data_in;

    assign gx_d  = (ext(p02) + (ext(p12) <<< 1) + ext(p22)) - (ext(p00) + (ext(p10) <<< 1) + ext(p20));
    assign gy_d  = (ext(p20) + (ext(p21) <<< 1) + ext(p22)) - (ext(p00) + (ext(p01) <<< 1) + ext(p02));
    assign ax_d  = absv(gx_d);
    assign ay_d  = absv(gy_d);
    assign sum_d = {1'b0, ax_d} + {1'b0, ay_d};

    // H as it will be once the final header byte currently on data_in is folded in.
    assign h_full_d = h_q | (DIM_W'(data_in) << DATA_W);
    assign bad_d    = (w_q < DIM_W'(3)) || (w_q > DIM_W'(MAX_W)) || (h_full_d < DIM_W'(3));
    assign wdim_d   = w_q - DIM_W'(2);
    assign hdim_d   = h_q - DIM_W'(2);

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign err       = err_q;

    // Select the filter output for the latched mode.
    always_comb begin
        res_d = sat(sum_d);
        case (mode_q)
            2'd1:    res_d = sat({1'b0, ax_d});
            2'd2:    res_d = sat({1'b0, ay_d});
            2'd3:    res_d = p11;
            default: res_d = sat(sum_d);
        endcase
    end

    // Accept input in HDR_IN and ERR, and in PIX whenever the output register can take a result.
    always_comb begin
        ready_in = 1'b0;
        if (!rst) begin
            case (state_q)
                HDR_IN, ERR: ready_in = 1'b1;
                PIX:         ready_in = !last_q && (!valid_q || ready_out);
                default:     ready_in = 1'b0;
            endcase
        end
    end

    // Frame control FSM with the registered output byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HDR_IN;
            hcnt_q  <= '0;
            ocnt_q  <= '0;
            w_q     <= '0;
            h_q     <= '0;
            col_q   <= '0;
            row_q   <= '0;
            mode_q  <= '0;
            last_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                HDR_IN: begin
                    if (in_xfer) begin
                        hcnt_q <= hcnt_q + 2'd1;
                        case (hcnt_q)
                            2'd0: begin
                                w_q    <= DIM_W'(data_in);
                                mode_q <= mode;
                            end
                            2'd1: w_q <= w_q | (DIM_W'(data_in) << DATA_W);
                            2'd2: h_q <= DIM_W'(data_in);
                            default: begin
                                h_q    <= h_full_d;
                                hcnt_q <= '0;
                                if (bad_d) begin
                                    state_q <= ERR;
                                    err_q   <= 1'b1;
                                end else begin
                                    state_q <= HDR_OUT;
                                    data_q  <= hdr_byte(2'd0, wdim_d, h_full_d - DIM_W'(2));
                                    valid_q <= 1'b1;
                                    ocnt_q  <= '0;
                                end
                            end
                        endcase
                    end
                end
                HDR_OUT: begin
                    if (out_xfer) begin
                        if (ocnt_q == 2'd3) begin
                            valid_q <= 1'b0;
                            state_q <= PIX;
                            col_q   <= '0;
                            row_q   <= '0;
                            last_q  <= 1'b0;
                            ocnt_q  <= '0;
                        end else begin
                            ocnt_q <= ocnt_q + 2'd1;
                            data_q <= hdr_byte(ocnt_q + 2'd1, wdim_d, hdim_d);
                        end
                    end
                end
                PIX: begin
                    if (out_xfer) begin
                        valid_q <= 1'b0;
                        if (last_q) begin
                            state_q <= HDR_IN;
                            last_q  <= 1'b0;
                        end
                    end
                    if (in_xfer) begin
                        if (col_q == w_q - DIM_W'(1)) begin
                            col_q <= '0;
                            row_q <= row_q + DIM_W'(1);
                            if (row_q == h_q - DIM_W'(1)) last_q <= 1'b1;
                        end else begin
                            col_q <= col_q + DIM_W'(1);
                        end
                        if (row_q >= DIM_W'(2) && col_q >= DIM_W'(2)) begin
                            data_q  <= res_d;
                            valid_q <= 1'b1;
                        end
                    end
                end
                ERR: begin
                    err_q   <= 1'b1;
                    valid_q <= 1'b0;
                end
                default: state_q <= HDR_IN;
            endcase
        end
    end

    // Shift the line buffers and the window on every accepted pixel.
    always_ff @(posedge clk) begin
        if (pix_acc) begin
            lb1_q[col_idx] <= mid_d;
            lb0_q[col_idx] <= data_in;
            win_q[0][0] <= win_q[0][1];
            win_q[1][0] <= win_q[1][1];
            win_q[2][0] <= win_q[2][1];
            win_q[0][1] <= top_d;
            win_q[1][1] <= mid_d;
            win_q[2][1] <= data_in;
        end
    end

endmodule
